store_buffer: RTL

Post-commit store queue between the MEM/WB pipeline stages and the data cache. Stores are allocated speculatively when they leave MEM. The write-back stage then either commits them (`store_buffer_we`) or cancels them (`store_buffer_ce`). Committed entries drain in program order to the dcache over a req/ack handshake, and a load address check tells MEM when a load must stall behind a buffered store.

---
 rtl/store_buffer_if.sv | 48 ++++
 rtl/store_buffer.sv | 115 +++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Store buffer bus: MEM push port, WB commit/cancel/flush controls,
// dcache write handshake and the MEM load-address check.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              push_valid_i;
    logic              push_ready_o;
    logic [ADDR_W-1:0] push_addr_i;
    logic [DATA_W-1:0] push_data_i;
    logic [STRB_W-1:0] push_wstrb_i;

    logic              commit_i;
    logic              cancel_i;
    logic              flush_i;

    logic              wr_req_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic [STRB_W-1:0] wr_wstrb_o;
    logic              wr_ack_i;

    logic [ADDR_W-1:0] ld_addr_i;
    logic              ld_hit_o;

    logic              empty_o;
    logic              full_o;

    // Pipeline/dcache side: drives stores, controls, acks and load addresses
    modport master (
        output push_valid_i, push_addr_i, push_data_i, push_wstrb_i,
        output commit_i, cancel_i, flush_i,
        output wr_ack_i, ld_addr_i,
        input  push_ready_o, wr_req_o, wr_addr_o, wr_data_o, wr_wstrb_o,
        input  ld_hit_o, empty_o, full_o
    );

    // Store buffer side
    modport slave (
        input  push_valid_i, push_addr_i, push_data_i, push_wstrb_i,
        input  commit_i, cancel_i, flush_i,
        input  wr_ack_i, ld_addr_i,
        output push_ready_o, wr_req_o, wr_addr_o, wr_data_o, wr_wstrb_o,
        output ld_hit_o, empty_o, full_o
    );
endinterface

// File: rtl/store_buffer.sv
// Post-commit store queue between MEM/WB and the data cache.
// Entries are allocated speculatively at tail, retire into the committed
// region at cptr, and drain in order from head over a req/ack handshake.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];
    logic [STRB_W-1:0] wstrb_mem [DEPTH];

    logic [PTR_W-1:0] head, cptr, tail;
    logic [PTR_W-1:0] head_nxt, cptr_nxt, tail_nxt;
    logic [CNT_W-1:0] cmt_cnt, spec_cnt;
    logic [CNT_W-1:0] cmt_cnt_nxt, spec_cnt_nxt;
    logic [CNT_W-1:0] occupancy;

    logic full;
    logic push_acc;
    logic commit_ok;
    logic ack_ok;
    logic kill_spec;
    logic [DEPTH-1:0] entry_valid;
    logic ld_hit;

    assign occupancy = cmt_cnt + spec_cnt;
    assign full      = (occupancy == CNT_W'(DEPTH));

    // A push in a cancel/flush cycle is dropped; commit wins over cancel,
    // while flush still drops whatever is speculative after a same-cycle commit.
    assign push_acc  = bus.push_valid_i & !full & !bus.flush_i & !bus.cancel_i;
    assign commit_ok = bus.commit_i & (spec_cnt != '0);
    assign ack_ok    = bus.wr_ack_i & (cmt_cnt != '0);
    assign kill_spec = bus.flush_i | (bus.cancel_i & !bus.commit_i);

    // Next pointer and counter values; each counter nets its own inc/dec
    always_comb begin
        head_nxt     = head + PTR_W'(ack_ok);
        cptr_nxt     = cptr + PTR_W'(commit_ok);
        tail_nxt     = tail;
        spec_cnt_nxt = spec_cnt;
        cmt_cnt_nxt  = cmt_cnt + CNT_W'(commit_ok) - CNT_W'(ack_ok);
        if (kill_spec) begin
            tail_nxt     = cptr_nxt;
            spec_cnt_nxt = '0;
        end else begin
            tail_nxt     = tail + PTR_W'(push_acc);
            spec_cnt_nxt = spec_cnt + CNT_W'(push_acc) - CNT_W'(commit_ok);
        end
    end

    // Pointer and counter registers; reset discards every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            cptr     <= '0;
            tail     <= '0;
            cmt_cnt  <= '0;
            spec_cnt <= '0;
        end else begin
            head     <= head_nxt;
            cptr     <= cptr_nxt;
            tail     <= tail_nxt;
            cmt_cnt  <= cmt_cnt_nxt;
            spec_cnt <= spec_cnt_nxt;
        end
    end

    // Entry payload storage; contents of free slots are don't-care
    always_ff @(posedge clk) begin
        if (push_acc) begin
            addr_mem[tail]  <= bus.push_addr_i;
            data_mem[tail]  <= bus.push_data_i;
            wstrb_mem[tail] <= bus.push_wstrb_i;
        end
    end

    // A slot is live when its distance from head is below the occupancy
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - head)) < occupancy;
        end
    end

    // Word-granular match of the load address against every live entry
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] &&
                (addr_mem[i][ADDR_W-1:2] == bus.ld_addr_i[ADDR_W-1:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign bus.push_ready_o = !full;
    assign bus.full_o       = full;
    assign bus.empty_o      = (occupancy == '0);
    assign bus.wr_req_o     = (cmt_cnt != '0);
    assign bus.wr_addr_o    = addr_mem[head];
    assign bus.wr_data_o    = data_mem[head];
    assign bus.wr_wstrb_o   = wstrb_mem[head];
    assign bus.ld_hit_o     = ld_hit;

endmodule
